// File: rtl/led_seq_monitor.sv
// led_seq_monitor
// Receive-side checker for the LED counter pattern. The pattern holds 0 while
// idle, then counts 1, 2 .. LAST one step per clock, then returns to 0. The
// block samples the bus on every clock, follows the pattern with an FSM,
// counts completed sequences and violations, and raises per-event pulses.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset; overrides every other input
//   en         monitor enable; 0 parks the FSM in SYNC, and counters hold
//   clr        synchronous clear of seq_cnt, err_cnt and err_sticky
//   led_in     observed LED bus
//   busy       1 while the registered state is RUN
//   seq_done   one-cycle pulse when a full 0,1..LAST,0 sequence completes
//   err        one-cycle pulse when a violation is detected
//   err_sticky set by any err; cleared only by rst or clr
//   seq_cnt    number of completed sequences, wraps
//   err_cnt    number of violations, saturates at all-ones
//   prev_led   registered copy of the previous led_in sample
//
// state | meaning
// SYNC  | waiting for the first 0 after reset or enable; nothing is checked
// IDLE  | bus at 0; a 1 starts a run, and any other nonzero value is an error
// RUN   | counting; every sample must be prev_led+1, or 0 right after LAST
// ERR   | violation already reported; waiting for 0 to resynchronise
module led_seq_monitor #(
   parameter int LED_W = 4,
   parameter int LAST  = 9,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic [LED_W-1:0] led_in,
   output logic             busy,
   output logic             seq_done,
   output logic             err,
   output logic             err_sticky,
   output logic [CNT_W-1:0] seq_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [LED_W-1:0] prev_led
);

   typedef enum logic [1:0] {SYNC, IDLE, RUN, ERR} state_t;

   localparam logic [LED_W-1:0] LAST_V  = LED_W'(LAST);
   localparam logic [LED_W-1:0] ONE_V   = LED_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           state_q;
   state_t           state_d;
   logic             done_d;
   logic             err_d;
   logic [LED_W-1:0] exp_next;

   // The increment is taken in LED_W bits. In RUN, prev_led never exceeds
   // LAST, so the wrapped value is never accepted as a legal step.
   assign exp_next = prev_led + ONE_V;

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      if (!en) begin
         state_d = SYNC;
      end else begin
         case (state_q)
            SYNC: begin
               if (led_in == '0) state_d = IDLE;
            end
            IDLE: begin
               if (led_in == ONE_V) begin
                  state_d = RUN;
               end else if (led_in != '0) begin
                  state_d = ERR;
                  err_d   = 1'b1;
               end
            end
            RUN: begin
               if ((prev_led < LAST_V) && (led_in == exp_next)) begin
                  state_d = RUN;
               end else if ((prev_led == LAST_V) && (led_in == '0)) begin
                  // The closing 0 also serves as the idle sample of the next run.
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ERR;
                  err_d   = 1'b1;
               end
            end
            ERR: begin
               if (led_in == '0) state_d = IDLE;
            end
            default: state_d = SYNC;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= SYNC;
         prev_led   <= '0;
         seq_done   <= 1'b0;
         err        <= 1'b0;
         err_sticky <= 1'b0;
         seq_cnt    <= '0;
         err_cnt    <= '0;
      end else begin
         state_q  <= state_d;
         prev_led <= led_in;
         seq_done <= done_d;
         err      <= err_d;
         // clr beats a same-cycle event: the pulse still fires, but the event
         // is not counted and does not set the sticky flag.
         if (clr) begin
            seq_cnt    <= '0;
            err_cnt    <= '0;
            err_sticky <= 1'b0;
         end else begin
            if (done_d) seq_cnt <= seq_cnt + CNT_W'(1);
            if (err_d) begin
               err_sticky <= 1'b1;
               if (err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_W'(1);
            end
         end
      end
   end

   assign busy = (state_q == RUN);

endmodule

// File: doc/led_seq_monitor.md
Name: led_seq_monitor

Overview:
Receive-side checker for the 4-bit LED count pattern produced by the LED counter block.
- The pattern is: hold 0 while idle, then +1 per clock from 1 up to LAST, then return to 0.
- The block samples the LED bus every clock and tracks the sequence with an FSM.
- It counts completed sequences and protocol violations, and raises per-event pulses and a sticky error.
- It sits beside the LED driver in the lab top level and in benches as a self-checking observer.

Parameters:
LED_W, 4, width of the observed LED bus
LAST, 9, final value of a run; legal range 1 .. 2^LED_W-1
CNT_W, 16, width of seq_cnt and err_cnt

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
en  input  1  monitor enable; 0 = checking disabled
clr  input  1  synchronous clear of counters and sticky error
led_in  input  LED_W  observed LED bus, sampled every clk edge
busy  output  1  1 while state == RUN
seq_done  output  1  one-cycle pulse: a full 0,1..LAST,0 sequence completed
err  output  1  one-cycle pulse: violation detected
err_sticky  output  1  set on any err; cleared only by rst or clr
seq_cnt  output  CNT_W  completed sequences, wraps modulo 2^CNT_W
err_cnt  output  CNT_W  violations, saturates at all-ones
prev_led  output  LED_W  registered copy of the last led_in sample

Behaviour:
- All outputs are registered. An event sampled at edge k is visible after edge k, for exactly one cycle for pulses.
- Reset (rst=1 at an edge) has priority over everything:
  - state = SYNC;
  - prev_led = 0;
  - busy, seq_done, err, err_sticky = 0;
  - seq_cnt, err_cnt = 0.
- States: SYNC, IDLE, RUN, ERR. prev_led <= led_in every edge unless rst.
- en=0: state forced to SYNC; no pulses; counters and err_sticky hold.
- SYNC:
  - led_in==0 -> IDLE;
  - otherwise stay in SYNC, no err.
- IDLE:
  - led_in==0 -> stay;
  - led_in==1 -> RUN;
  - any other value -> ERR, with err pulse.
- RUN (expected value = prev_led+1, computed in LED_W bits):
  - prev_led<LAST and led_in==prev_led+1 -> stay in RUN;
  - prev_led==LAST and led_in==0 -> IDLE, seq_done pulse, seq_cnt+1;
  - anything else (stall, skip, early 0, value >LAST) -> ERR, err pulse.
- ERR:
  - led_in==0 -> IDLE;
  - otherwise stay;
  - no repeated err pulses while in ERR.
- Each err pulse sets err_sticky and increments err_cnt, saturating at 2^CNT_W-1.
- seq_cnt wraps from all-ones to 0.
- clr=1 (rst=0):
  - seq_cnt, err_cnt, err_sticky load 0 and take priority over any same-cycle increment or set (that event is not counted);
  - seq_done and err pulses still fire;
  - FSM is unaffected.
- Back-to-back sequences:
  - the 0 closing one run counts as the IDLE sample for the next;
  - led_in==1 on the following edge starts a new RUN with no idle gap required.
- Reset mid-RUN discards the partial sequence with no pulse. The first 0 sample after reset moves SYNC -> IDLE.
- busy = 1 exactly in cycles where the registered state is RUN.

Test Plan:
- Reset, hold led_in=0 for 3 clk, drive 1..9 then 0 -> state SYNC->IDLE->RUN; busy high for 9 cycles; seq_done one pulse after the 0 sample; seq_cnt=1; err=0.
- Two back-to-back runs 0,1..9,0,1..9,0 -> seq_cnt=2; exactly two seq_done pulses; err_cnt=0.
- Run 0,1,2,4 -> err pulse after the 4 sample; err_sticky=1; err_cnt=1; further values 5,6 give no more pulses; then 0,1..9,0 -> seq_cnt=1; err_sticky still 1.
- Stall 0,1,2,2 and early return 0,1..5,0 in separate runs -> err_cnt=2, seq_cnt=0. Then clr=1 on the same cycle as a seq_done -> seq_cnt=0, err_cnt=0, err_sticky=0, seq_done pulse still seen.
- Reset with led_in=5, hold 5 for 4 clk, then 0 -> no err while in SYNC; IDLE reached. Drop en=0 mid-run at value 3, re-enable at value 6 -> no err until the next 0; the sequence after that counts normally.
- With CNT_W=2: complete 5 sequences -> seq_cnt reads 1 (wrap). Inject 5 violations -> err_cnt=3 (saturated).
